// File: rtl/dtpu_infifo.sv
// Input stream FIFO for dtpu_core: an AXI-Stream slave write side and a
// first-word-fall-through read side, with tlast stored alongside each word.
module dtpu_infifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       flush,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [DATA_WIDTH-1:0]      rd_data,
  input  logic                       rd_en,
  output logic                       rd_empty_n,
  output logic                       rd_last,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  // Handshake: a word transfers on an edge where s_axis_tvalid and
  // s_axis_tready are both high; the producer must hold tdata/tlast stable
  // while tvalid is high and tready is low. tready depends only on
  // registered level, aresetn and flush, never on tvalid or rd_en.

  logic [DATA_WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          level_q;
  logic                 underflow_q;
  logic                 empty;
  logic                 wr_fire;
  logic                 rd_fire;
  logic [DATA_WIDTH:0]  head;

  assign empty         = (level_q == '0);
  assign s_axis_tready = aresetn && !flush && (level_q != LEVEL_FULL);
  assign wr_fire       = s_axis_tvalid && s_axis_tready;
  // A pop on an empty FIFO is ignored, even if a write lands on the same edge.
  assign rd_fire       = rd_en && !empty && !flush;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      if (wr_fire && !rd_fire)      level_q <= level_q + (AW + 1)'(1);
      else if (rd_fire && !wr_fire) level_q <= level_q - (AW + 1)'(1);
      if (rd_en && empty) underflow_q <= 1'b1;
    end
  end

  // Storage carries no reset; wr_fire is already gated by reset and flush.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
  end

  assign head       = mem[rd_ptr];
  assign rd_data    = empty ? '0 : head[DATA_WIDTH-1:0];
  assign rd_last    = empty ? 1'b0 : head[DATA_WIDTH];
  assign rd_empty_n = !empty;
  assign level      = level_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_dtpu_infifo.sv
// Self-checking bench for dtpu_infifo: directed scenarios plus a random run,
// all compared against a queue-based reference model of the FIFO.
module tb_dtpu_infifo;

  localparam int W     = 64;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  // clock / reset block
  logic          clk = 1'b0;
  logic          aresetn;
  logic          flush;
  logic [W-1:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [W-1:0]  rd_data;
  logic          rd_en;
  logic          rd_empty_n;
  logic          rd_last;
  logic [LW-1:0] level;
  logic          underflow;

  always #5 clk = ~clk;

  dtpu_infifo #(.DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .flush         (flush),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .rd_data       (rd_data),
    .rd_en         (rd_en),
    .rd_empty_n    (rd_empty_n),
    .rd_last       (rd_last),
    .level         (level),
    .underflow     (underflow)
  );

  // scoreboard: expected contents as {tlast, tdata}, oldest first
  logic [W:0] exp_q[$];
  logic       exp_uf;
  int         n_checks = 0;
  int         n_pass   = 0;

  function automatic logic [W-1:0] exp_data();
    return (exp_q.size() == 0) ? '0 : exp_q[0][W-1:0];
  endfunction

  function automatic logic exp_last();
    return (exp_q.size() == 0) ? 1'b0 : exp_q[0][W];
  endfunction

  function automatic logic exp_ready();
    return aresetn && !flush && (exp_q.size() < DEPTH);
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  // driver tasks
  task automatic idle();
    flush = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tdata = '0; rd_en = 1'b0;
  endtask

  // Advance one clock edge, updating the model from the inputs in force.
  task automatic tick();
    bit had, can_wr;
    if (!aresetn || flush) begin
      exp_q.delete();
      exp_uf = 1'b0;
    end else begin
      had    = (exp_q.size() > 0);
      can_wr = s_axis_tvalid && (exp_q.size() < DEPTH);
      if (rd_en && !had) exp_uf = 1'b1;
      if (rd_en && had) void'(exp_q.pop_front());
      if (can_wr) exp_q.push_back({s_axis_tlast, s_axis_tdata});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [W-1:0] d, input logic l);
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = l;
    tick();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    aresetn = 1'b0;
    s_axis_tvalid = 1'b1;
    tick(); tick();
    n_checks++;
    if (s_axis_tready !== 1'b0) $display("FAIL reset_tready got %b exp 0", s_axis_tready); else n_pass++;
    n_checks++;
    if (level !== '0 || rd_empty_n !== 1'b0 || underflow !== 1'b0)
      $display("FAIL reset_state got level=%0d empty_n=%b uf=%b exp 0/0/0", level, rd_empty_n, underflow);
    else n_pass++;
    n_checks++;
    if (rd_data !== '0 || rd_last !== 1'b0) $display("FAIL reset_rd got %h/%b exp 0/0", rd_data, rd_last); else n_pass++;
    aresetn = 1'b1;
    s_axis_tvalid = 1'b0;
    #1;
    n_checks++;
    if (s_axis_tready !== 1'b1) $display("FAIL reset_release_tready got %b exp 1", s_axis_tready); else n_pass++;
  endtask

  task automatic test_basic_order();
    logic [W-1:0] want [3];
    want[0] = 64'h11; want[1] = 64'h22; want[2] = 64'h33;
    write_word(want[0], 1'b0);
    n_checks++;
    if (rd_empty_n !== 1'b1 || rd_data !== want[0])
      $display("FAIL basic_latency got empty_n=%b data=%h exp 1/%h", rd_empty_n, rd_data, want[0]);
    else n_pass++;
    write_word(want[1], 1'b0);
    write_word(want[2], 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rd_data !== want[i] || rd_data !== exp_data() || rd_last !== (i == 2))
        $display("FAIL basic_pop%0d got %h/%b exp %h/%b", i, rd_data, rd_last, want[i], (i == 2));
      else n_pass++;
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    n_checks++;
    if (rd_empty_n !== 1'b0 || rd_data !== '0 || level !== '0)
      $display("FAIL basic_drained got empty_n=%b data=%h level=%0d exp 0/0/0", rd_empty_n, rd_data, level);
    else n_pass++;
  endtask

  task automatic test_full();
    logic [W-1:0] w17;
    do_flush();
    for (int i = 0; i < DEPTH; i++) write_word(rand_word(), 1'($urandom_range(0, 1)));
    n_checks++;
    if (level !== LW'(DEPTH) || s_axis_tready !== 1'b0)
      $display("FAIL full_level got level=%0d tready=%b exp %0d/0", level, s_axis_tready, DEPTH);
    else n_pass++;
    w17 = rand_word();
    s_axis_tvalid = 1'b1; s_axis_tdata = w17; s_axis_tlast = 1'b1;
    tick();
    n_checks++;
    if (level !== LW'(DEPTH)) $display("FAIL full_holdoff got level=%0d exp %0d", level, DEPTH); else n_pass++;
    rd_en = 1'b1;
    #1;
    n_checks++;
    if (s_axis_tready !== 1'b0) $display("FAIL full_no_comb_path got tready=%b exp 0", s_axis_tready); else n_pass++;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (level !== LW'(DEPTH - 1) || s_axis_tready !== 1'b1)
      $display("FAIL full_after_pop got level=%0d tready=%b exp %0d/1", level, s_axis_tready, DEPTH - 1);
    else n_pass++;
    tick();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    n_checks++;
    if (level !== LW'(DEPTH) || exp_q[DEPTH-1] !== {1'b1, w17})
      $display("FAIL full_w17_accept got level=%0d exp %0d", level, DEPTH);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (rd_data !== exp_data() || rd_last !== exp_last())
        $display("FAIL full_drain%0d got %h/%b exp %h/%b", i, rd_data, rd_last, exp_data(), exp_last());
      else n_pass++;
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    n_checks++;
    if (rd_empty_n !== 1'b0) $display("FAIL full_empty got %b exp 0", rd_empty_n); else n_pass++;
  endtask

  task automatic test_underflow();
    do_flush();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    n_checks++;
    if (underflow !== 1'b1 || level !== '0)
      $display("FAIL uf_set got uf=%b level=%0d exp 1/0", underflow, level);
    else n_pass++;
    tick();
    n_checks++;
    if (underflow !== 1'b1) $display("FAIL uf_sticky got %b exp 1", underflow); else n_pass++;
    do_flush();
    n_checks++;
    if (underflow !== 1'b0) $display("FAIL uf_flush got %b exp 0", underflow); else n_pass++;
    s_axis_tvalid = 1'b1; s_axis_tdata = 64'h5A5A; rd_en = 1'b1;
    tick();
    idle();
    n_checks++;
    if (level !== LW'(1) || underflow !== 1'b1 || rd_data !== 64'h5A5A)
      $display("FAIL uf_wr_pop_empty got level=%0d uf=%b data=%h exp 1/1/5a5a", level, underflow, rd_data);
    else n_pass++;
    do_flush();
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    do_flush();
    for (int i = 0; i < 5; i++) write_word(rand_word(), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 20; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = rand_word(); s_axis_tlast = 1'($urandom_range(0, 1));
      rd_en = 1'b1;
      #1;
      n_checks++;
      if (rd_data !== exp_data() || rd_last !== exp_last()) begin
        $display("FAIL b2b_word%0d got %h/%b exp %h/%b", i, rd_data, rd_last, exp_data(), exp_last());
        bad++;
      end else n_pass++;
      tick();
    end
    idle();
    n_checks++;
    if (level !== LW'(5)) $display("FAIL b2b_level got %0d exp 5", level); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rd_data !== exp_data()) $display("FAIL b2b_tail%0d got %h exp %h", i, rd_data, exp_data()); else n_pass++;
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    do_flush();
    for (int i = 0; i < 8; i++) write_word(rand_word(), 1'b0);
    n_checks++;
    if (level !== LW'(8)) $display("FAIL mrst_level8 got %0d exp 8", level); else n_pass++;
    aresetn = 1'b0; tick(); aresetn = 1'b1;
    n_checks++;
    if (level !== '0 || rd_empty_n !== 1'b0 || rd_data !== '0)
      $display("FAIL mrst_cleared got level=%0d empty_n=%b data=%h exp 0/0/0", level, rd_empty_n, rd_data);
    else n_pass++;
    write_word(64'hAB, 1'b0);
    n_checks++;
    if (rd_data !== 64'hAB || rd_empty_n !== 1'b1)
      $display("FAIL mrst_first got %h/%b exp ab/1", rd_data, rd_empty_n);
    else n_pass++;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
  endtask

  task automatic test_random();
    do_flush();
    for (int i = 0; i < 400; i++) begin
      s_axis_tvalid = ($urandom_range(0, 99) < 60);
      s_axis_tdata  = rand_word();
      s_axis_tlast  = 1'($urandom_range(0, 1));
      rd_en         = ($urandom_range(0, 99) < 50);
      flush         = ($urandom_range(0, 99) < 2);
      #1;
      n_checks++;
      if (rd_data !== exp_data() || rd_last !== exp_last() || level !== LW'(exp_q.size()) ||
          rd_empty_n !== (exp_q.size() != 0) || s_axis_tready !== exp_ready() || underflow !== exp_uf)
        $display("FAIL rand_cyc%0d got data=%h last=%b level=%0d rdy=%b uf=%b exp %h/%b/%0d/%b/%b",
                 i, rd_data, rd_last, level, s_axis_tready, underflow,
                 exp_data(), exp_last(), exp_q.size(), exp_ready(), exp_uf);
      else n_pass++;
      tick();
    end
    idle();
  endtask

  initial begin
    exp_uf = 1'b0;
    aresetn = 1'b0;
    idle();
    test_reset();
    test_basic_order();
    test_full();
    test_underflow();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dtpu_infifo.md
DTPU_INFIFO -- requirements
Module: dtpu_infifo

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of stream and read data.
REQ-002 Parameter DEPTH, default 16, number of words stored; power of two, at least 2.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 aresetn  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  synchronous clear of contents; active-high.
REQ-006 s_axis_tdata  input  DATA_WIDTH  AXI-Stream slave write data.
REQ-007 s_axis_tvalid  input  1  AXI-Stream slave valid.
REQ-008 s_axis_tlast  input  1  AXI-Stream slave end-of-tensor marker.
REQ-009 s_axis_tready  output  1  AXI-Stream slave ready.
REQ-010 rd_data  output  DATA_WIDTH  head word, first-word-fall-through (acc_fifo_read RD_DATA).
REQ-011 rd_en  input  1  pop request from dtpu_core (acc_fifo_read RD_EN).
REQ-012 rd_empty_n  output  1  high while at least one word is stored (acc_fifo_read EMPTY_N).
REQ-013 rd_last  output  1  tlast bit stored with the head word.
REQ-014 level  output  log2(DEPTH)+1  current number of stored words.
REQ-015 underflow  output  1  sticky flag: pop attempted while empty.

Function
REQ-016 Storage is a DEPTH-entry circular buffer of {tlast, tdata} with write and read pointers of log2(DEPTH) bits; both pointers wrap from DEPTH-1 to 0.
REQ-017 s_axis_tready = 1 when level < DEPTH and flush = 0; otherwise 0.
REQ-018 A write occurs on a clock edge where s_axis_tvalid and s_axis_tready are both 1; it stores the word at the write pointer and advances the pointer.
REQ-019 A pop occurs on a clock edge where rd_en = 1 and level > 0; it advances the read pointer.
REQ-020 rd_data and rd_last are driven combinationally from the entry at the read pointer. They are valid whenever rd_empty_n = 1, so the consumer latches rd_data in the same cycle it asserts rd_en.
REQ-021 When level = 0, rd_data is forced to 0 and rd_last is forced to 0.
REQ-022 rd_empty_n = (level != 0), derived from registered state only.
REQ-023 Level update per edge:
- +1 on a write with no pop.
- -1 on a pop with no write.
- unchanged on a simultaneous write and pop.
REQ-024 Simultaneous write and pop at level = 0: the write is accepted and the pop is ignored. Level becomes 1 and underflow is set.
REQ-025 At level = DEPTH, s_axis_tready = 0, so no write occurs. A pop in that cycle reduces level to DEPTH-1, and tready rises the next cycle; there is no combinational path from rd_en to tready.
REQ-026 rd_en at level = 0 does not change any pointer and sets underflow; underflow stays set until reset or flush.
REQ-027 flush = 1 on an edge sets both pointers and level to 0 and clears underflow. Writes and pops in that cycle are discarded.
REQ-028 Write latency: a word accepted at edge N is visible on rd_data and raises rd_empty_n after edge N.
REQ-029 Word order on the read side equals acceptance order; tlast travels with its word unchanged.

Reset
REQ-030 While aresetn = 0 at an edge, the block clears pointers, level and underflow. This gives s_axis_tready = 0 during reset, then 1 after release, and rd_empty_n = 0, rd_data = 0, rd_last = 0.
REQ-031 Reset asserted mid-stream drops all stored words; no stale word is presented after release.
REQ-032 Memory contents need no reset; only the pointers, level and flags are reset.
REQ-033 Reset takes priority over flush; flush takes priority over write and pop.

Verification
REQ-034 Reset, then write 0x11,0x22,0x33 (tlast on 0x33), then pop three times -> rd_data 0x11,0x22,0x33 in order, rd_last = 1 only with 0x33, then rd_empty_n = 0 and rd_data = 0.
REQ-035 Write 16 words with DEPTH = 16 and no pops -> level = 16, s_axis_tready = 0, word 17 held off. One pop -> tready = 1 the next cycle and word 17 is accepted at the tail.
REQ-036 Pop at level = 0 -> underflow = 1, level stays 0. A later flush -> underflow = 0.
REQ-037 Level 5 with tvalid and rd_en held high for 20 cycles -> level stays 5 and output order is preserved across pointer wrap.
REQ-038 Level 8, then aresetn = 0 for one cycle -> level = 0 and rd_empty_n = 0. The next written word 0xAB appears first on rd_data.
